// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit for the rv32i MEM stage.
// Turns one load or store into a registered data-memory request and holds it
// until mem_ack. The pipeline stalls for the whole access. The unit
// sign/zero-extends load data and flags misaligned accesses, illegal funct3
// codes and bus timeouts.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_valid/i_load/i_store    MEM-stage instruction qualifiers
//   i_fun3, i_addr            instruction[14:12], effective address
//   i_store_data              rs2 value
//   o_mem_req/we/addr/mask    registered memory request (word address)
//   o_mem_wdata               lane-replicated store data
//   i_mem_ack, i_mem_rdata    memory response
//   o_stall                   freeze upstream pipeline
//   o_load_data, o_load_done  extended load result and its one-cycle strobe
//   o_err, o_err_code         error pulse; code 01 misalign, 10 timeout,
//                             11 illegal funct3 (code held until next error)
//
// state | meaning
// IDLE  | no access outstanding, accepts new work
// REQ   | request on the bus, waiting for ack or timeout
// DONE  | access finished this cycle, pipeline advances, accepts new work
module mem_stage_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_fun3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_store_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_mask,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_stall,
  output logic [31:0]       o_load_data,
  output logic              o_load_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT_CYC);
  localparam logic                 TO_EN  = (TIMEOUT_CYC != 0);

  logic [1:0]           r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [2:0]           r_fun3;
  logic [1:0]           r_lane;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [3:0]           r_mem_mask;
  logic [31:0]          r_mem_wdata;
  logic [31:0]          r_load_data;
  logic                 r_load_done;
  logic                 r_err;
  logic [1:0]           r_err_code;

  logic                 w_one_op;
  logic                 w_legal;
  logic                 w_aligned;
  logic                 w_accepting;
  logic                 w_start;
  logic                 w_reject;
  logic [TIMEOUT_W-1:0] w_cnt_next;
  logic                 w_timeout;
  logic [3:0]           w_mask;
  logic [31:0]          w_wdata;
  logic [7:0]           w_rbyte;
  logic [15:0]          w_rhalf;
  logic [31:0]          w_ext;

  // load & store together is treated as no operation at all
  assign w_one_op = i_load ^ i_store;

  always_comb begin
    w_legal = 1'b0;
    if (i_load) begin
      case (i_fun3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end else begin
      case (i_fun3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    w_mask    = 4'b1111;
    w_wdata   = i_store_data;
    case (i_fun3[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        w_aligned = ~i_addr[0];
        w_mask    = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata   = {2{i_store_data[15:0]}};
      end
      default: w_aligned = (i_addr[1:0] == 2'b00);
    endcase
  end

  // DONE takes new work exactly like IDLE
  assign w_accepting = (r_state != S_REQ);
  assign w_start     = w_accepting & i_valid & w_one_op & w_legal & w_aligned;
  assign w_reject    = w_accepting & i_valid & w_one_op & ~(w_legal & w_aligned);

  assign w_cnt_next = r_cnt + 1'b1;
  // ack has priority over timeout in the same cycle (see REQ branch)
  assign w_timeout  = TO_EN & (w_cnt_next == TO_VAL);

  assign w_rbyte = i_mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_rhalf = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    case (r_fun3)
      3'b000:  w_ext = {{24{w_rbyte[7]}}, w_rbyte};
      3'b001:  w_ext = {{16{w_rhalf[15]}}, w_rhalf};
      3'b100:  w_ext = {24'd0, w_rbyte};
      3'b101:  w_ext = {16'd0, w_rhalf};
      default: w_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fun3      <= 3'd0;
      r_lane      <= 2'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_mask  <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_REQ: begin
          r_cnt <= w_cnt_next;
          if (i_mem_ack) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_load_data <= w_ext;
              r_load_done <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            r_mem_req   <= 1'b0;
            r_load_data <= 32'd0;
            r_err       <= 1'b1;
            r_err_code  <= 2'b10;
          end
        end
        default: begin
          if (w_start) begin
            r_state     <= S_REQ;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_store;
            r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            r_mem_mask  <= w_mask;
            r_mem_wdata <= w_wdata;
            r_fun3      <= i_fun3;
            r_lane      <= i_addr[1:0];
          end else begin
            r_state <= S_IDLE;
            if (w_reject) begin
              r_err      <= 1'b1;
              r_err_code <= w_legal ? 2'b01 : 2'b11;
            end
          end
        end
      endcase
    end
  end

  assign o_stall     = (r_state == S_REQ) | w_start;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_mask  = r_mem_mask;
  assign o_mem_wdata = r_mem_wdata;
  assign o_load_data = r_load_data;
  assign o_load_done = r_load_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed transactions, a transaction-level
// reference model compared against the DUT every cycle, and literal
// expectations for the documented scenarios.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0, load = 1'b0, store = 1'b0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, stall, load_done, err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_mask;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO), .TIMEOUT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_load(load),
    .i_store(store), .i_fun3(fun3), .i_addr(addr), .i_store_data(store_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_mask(mem_mask), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .o_stall(stall), .o_load_data(load_data),
    .o_load_done(load_done), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit f3_legal(input logic is_ld, input logic [2:0] f);
    if (is_ld) return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2);
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic [3:0] mask_of(input logic [31:0] a, input int n);
    logic [3:0] m;
    m = 4'((1 << n) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] repl(input logic [31:0] sd, input int n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] rd, input logic [2:0] f, input int lane);
    logic [31:0] v;
    int n;
    n = nbytes(f);
    if (n == 4) return rd;
    v = rd >> (8 * lane);
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  logic        m_busy, m_isld, m_req, m_we, m_ld_done, m_err;
  logic [31:0] m_addr, m_wdata, m_ld;
  logic [3:0]  m_mask;
  logic [1:0]  m_code;
  logic [2:0]  m_f3;
  int          m_lane, m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_isld <= 0; m_req <= 0; m_we <= 0; m_ld_done <= 0; m_err <= 0;
      m_addr <= 0; m_wdata <= 0; m_ld <= 0; m_mask <= 0; m_code <= 0;
      m_f3 <= 0; m_lane <= 0; m_wait <= 0;
    end else begin
      m_ld_done <= 0;
      m_err <= 0;
      if (!m_busy) begin
        if (valid && (load ^ store)) begin
          if (!f3_legal(load, fun3)) begin
            m_err <= 1; m_code <= 2'b11;
          end else if ((addr % nbytes(fun3)) != 0) begin
            m_err <= 1; m_code <= 2'b01;
          end else begin
            m_busy <= 1; m_wait <= 0; m_req <= 1; m_we <= store; m_isld <= load;
            m_addr <= addr & ~32'd3;
            m_mask <= mask_of(addr, nbytes(fun3));
            m_wdata <= repl(store_data, nbytes(fun3));
            m_f3 <= fun3; m_lane <= int'(addr % 4);
          end
        end
      end else begin
        if (mem_ack) begin
          m_busy <= 0; m_req <= 0;
          if (m_isld) begin
            m_ld <= extend(mem_rdata, m_f3, m_lane);
            m_ld_done <= 1;
          end
        end else if (TO > 0 && m_wait + 1 == TO) begin
          m_busy <= 0; m_req <= 0; m_ld <= 0; m_err <= 1; m_code <= 2'b10;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  // Stall is the only combinational output: busy, or a request accepted now.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall},
          {31'd0, m_busy | (!m_busy && valid && (load ^ store) && f3_legal(load, fun3)
                           && (addr % nbytes(fun3)) == 0)});
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
      if (m_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_mask", {28'd0, mem_mask}, {28'd0, m_mask});
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("load_done", {31'd0, load_done}, {31'd0, m_ld_done});
      chk("load_data", load_data, m_ld);
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("err_code", {30'd0, err_code}, {30'd0, m_code});
    end
  end

  // ---------------- stimulus ----------------
  int          req_cyc, stall_cyc, n_ld_done, n_err;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_mask;

  // Called at posedge+1. Presents the instruction for one cycle, then runs
  // 8 more cycles, raising mem_ack in the ack_at-th cycle (0 = never).
  task automatic txn(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input int ack_at, input logic [31:0] rd);
    bit seen;
    seen = 0;
    req_cyc = 0; stall_cyc = 0; n_ld_done = 0; n_err = 0;
    valid = 1; load = ld; store = st; fun3 = f3; addr = a; store_data = sd;
    mem_rdata = rd; mem_ack = 0;
    @(negedge clk);
    if (stall) stall_cyc++;
    @(posedge clk); #1;
    valid = 0; load = 0; store = 0;
    for (int k = 1; k <= 8; k++) begin
      mem_ack = (k == ack_at);
      @(negedge clk);
      if (mem_req) begin
        req_cyc++;
        if (!seen) begin
          seen = 1; s_we = mem_we; s_addr = mem_addr; s_mask = mem_mask; s_wdata = mem_wdata;
        end
      end
      if (stall) stall_cyc++;
      if (load_done) n_ld_done++;
      if (err) n_err++;
      @(posedge clk); #1;
    end
    mem_ack = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);

    // LW, ack on 3rd REQ cycle
    txn(1, 0, 3'b010, 32'h100, 32'd0, 3, 32'hDEAD_BEEF);
    chk("lw_req_cycles", req_cyc, 3);
    chk("lw_stall_cycles", stall_cyc, 4);
    chk("lw_we", {31'd0, s_we}, 32'd0);
    chk("lw_mask", {28'd0, s_mask}, 32'hF);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_done", n_ld_done, 1);
    chk("lw_data", load_data, 32'hDEAD_BEEF);

    // SB at 0x203
    txn(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 1, 32'd0);
    chk("sb_addr", s_addr, 32'h200);
    chk("sb_mask", {28'd0, s_mask}, 32'h8);
    chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'd0, s_we}, 32'd1);
    chk("sb_no_done", n_ld_done, 0);
    chk("sb_stall_cycles", stall_cyc, 2);

    // SH at 0x302
    txn(0, 1, 3'b001, 32'h302, 32'h1234_BEEF, 2, 32'd0);
    chk("sh_mask", {28'd0, s_mask}, 32'hC);
    chk("sh_wdata", s_wdata, 32'hBEEF_BEEF);

    // byte / half loads with extension
    txn(1, 0, 3'b000, 32'h102, 32'd0, 1, 32'h0080_0000);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_mask", {28'd0, s_mask}, 32'h4);
    txn(1, 0, 3'b100, 32'h102, 32'd0, 1, 32'h0080_0000);
    chk("lbu_data", load_data, 32'h0000_0080);
    txn(1, 0, 3'b001, 32'h102, 32'd0, 2, 32'h8001_0000);
    chk("lh_data", load_data, 32'hFFFF_8001);
    txn(1, 0, 3'b101, 32'h100, 32'd0, 1, 32'h1234_9ABC);
    chk("lhu_data", load_data, 32'h0000_9ABC);

    // errors
    txn(1, 0, 3'b010, 32'h102, 32'd0, 0, 32'd0);
    chk("mis_req_cycles", req_cyc, 0);
    chk("mis_stall_cycles", stall_cyc, 0);
    chk("mis_err_pulses", n_err, 1);
    chk("mis_code", {30'd0, err_code}, 32'h1);
    txn(0, 1, 3'b011, 32'h101, 32'd0, 0, 32'd0);
    chk("ill_err_pulses", n_err, 1);
    chk("ill_code", {30'd0, err_code}, 32'h3);

    // load & store together: nothing happens
    txn(1, 1, 3'b010, 32'h100, 32'd0, 0, 32'd0);
    chk("both_req_cycles", req_cyc, 0);
    chk("both_err", n_err, 0);
    chk("both_stall", stall_cyc, 0);

    // timeout and ack on the timeout cycle
    txn(1, 0, 3'b010, 32'h400, 32'd0, 0, 32'd0);
    chk("to_req_cycles", req_cyc, 4);
    chk("to_err_pulses", n_err, 1);
    chk("to_code", {30'd0, err_code}, 32'h2);
    chk("to_load_data", load_data, 32'd0);
    chk("to_no_done", n_ld_done, 0);
    txn(1, 0, 3'b010, 32'h404, 32'd0, 4, 32'h1234_5678);
    chk("ack4_req_cycles", req_cyc, 4);
    chk("ack4_err", n_err, 0);
    chk("ack4_data", load_data, 32'h1234_5678);

    // reset in the 2nd REQ cycle
    valid = 1; load = 1; store = 0; fun3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    valid = 0; load = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;

    // back-to-back SW then LW from DONE
    valid = 1; store = 1; fun3 = 3'b010; addr = 32'h300; store_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    valid = 0; store = 0; mem_ack = 1;
    @(negedge clk);
    chk("b2b_sw_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_sw_wdata", mem_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    mem_ack = 0;
    valid = 1; load = 1; fun3 = 3'b010; addr = 32'h304; mem_rdata = 32'h0BAD_C0DE;
    @(negedge clk);
    chk("b2b_done_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    valid = 0; load = 0; mem_ack = 1;
    @(negedge clk);
    chk("b2b_lw_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_lw_addr", mem_addr, 32'h304);
    chk("b2b_lw_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("b2b_lw_done", {31'd0, load_done}, 32'd1);
    chk("b2b_lw_data", load_data, 32'h0BAD_C0DE);

    // stray ack while idle
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("stray_ack_done", {31'd0, load_done}, 32'd0);
    chk("stray_ack_data", load_data, 32'h0BAD_C0DE);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised load/store unit for the MEM stage of the rv32i pipeline. It accepts one load or store per instruction and generates the byte-lane mask and lane-replicated store data. It holds a registered request to data memory until acknowledged, stalling the pipeline for the whole access. It also sign- or zero-extends load data, and detects misaligned accesses, illegal funct3 codes and bus timeouts.

Parameters:
ADDR_W, 32, address width; mem_addr is word-aligned with bits [1:0] forced to 0
TIMEOUT_CYC, 255, maximum cycles in REQ without an ack before a timeout; 0 disables the timeout
TIMEOUT_W, 8, width of the wait counter; must satisfy TIMEOUT_CYC < 2**TIMEOUT_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
valid  input  1  MEM-stage instruction valid
load  input  1  instruction is a load
store  input  1  instruction is a store
fun3  input  3  instruction[14:12]
addr  input  ADDR_W  effective address from the ALU
store_data  input  32  rs2 (op_b)
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write, 0 = read; valid only while mem_req is high
mem_addr  output  ADDR_W  word address
mem_mask  output  4  byte-lane enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory response (data_valid)
mem_rdata  input  32  read word
stall  output  1  freeze upstream pipeline
load_data  output  32  extended load result
load_done  output  1  one-cycle pulse; load_data valid
err  output  1  one-cycle error pulse
err_code  output  2  01 misalign, 10 timeout, 11 illegal funct3; held until the next err

Behaviour:
- Reset (rst=0, async): state=IDLE. mem_req, mem_we, load_done, err = 0. mem_addr, mem_mask, mem_wdata, load_data, err_code = 0. The wait counter is cleared. Reset mid-access drops mem_req immediately and discards the access.
- States: IDLE, REQ, DONE. DONE accepts new work exactly like IDLE.
- Start condition = valid & (load ^ store) & legal funct3 & aligned.
  - Legal funct3 for loads: 000, 001, 010, 100, 101.
  - Legal funct3 for stores: 000, 001, 010.
- load & store both high: no access, no err, stall=0.
- Aligned means:
  - byte accesses: always aligned;
  - halfword: addr[0]=0;
  - word: addr[1:0]=0.
- Mask:
  - byte: 4'b0001 << addr[1:0];
  - halfword: 4'b0011 << {addr[1],1'b0};
  - word: 4'b1111.
  - Loads drive the mask the same way as stores.
- mem_wdata: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data. mem_wdata is don't-care for loads but registered anyway.
- IDLE/DONE with start:
  - register mem_addr, mem_mask, mem_wdata, mem_we=store, fun3 and addr[1:0];
  - set mem_req=1 from the next cycle;
  - go to REQ;
  - stall=1 combinationally in the accepting cycle.
- IDLE/DONE with valid & (load|store) but illegal funct3 or misaligned:
  - no request;
  - err=1 on the next cycle with err_code 11 or 01; illegal funct3 takes priority;
  - stall=0.
- REQ:
  - stall=1; the payload is held stable; the counter increments each cycle.
  - If mem_ack=1: mem_req=0 next cycle and go to DONE. For loads, capture load_data from mem_rdata using the latched lane and fun3:
    - LB/LBU: byte at lane, sign/zero extended;
    - LH/LHU: half at addr[1], sign/zero extended;
    - LW: the full word.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC without an ack: mem_req=0, go to DONE, load_data=0, err=1, err_code=10.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYC wins; no timeout is raised.
- DONE:
  - stall=0 for one cycle; the pipeline advances.
  - load_done=1 only for a load that completed with an ack.
  - A stores completing produces no load_done.
- mem_ack is ignored outside REQ. A stray ack has no effect.
- Access latency = 1 (issue) + N (memory cycles until ack) + 1 (DONE). With an ack on the first REQ cycle, the stall lasts 2 cycles.

Test Plan:
- LW addr=0x100, rdata=0xDEADBEEF, ack on the 3rd REQ cycle -> mem_req high for 3 cycles, mem_we=0, mask=1111, stall high for 4 cycles, load_done with load_data=0xDEADBEEF.
- SB addr=0x203, store_data=0x000000A5 -> mem_addr=0x200, mask=1000, wdata=0xA5A5A5A5, mem_we=1, no load_done.
- LB at lane 2 and LBU at lane 2, rdata=0x00800000 -> load_data=0xFFFFFF80, then 0x00000080. LH at addr[1]=1, rdata=0x80010000 -> 0xFFFF8001.
- LW addr=0x102 -> no mem_req, err pulse with err_code=01, stall=0. Store with funct3=011 -> err_code=11.
- TIMEOUT_CYC=4, no ack -> mem_req drops after 4 REQ cycles, err_code=10, load_data=0. An ack on the 4th cycle completes normally with no err.
- rst asserted in the 2nd REQ cycle -> mem_req=0 immediately. After release the FSM is in IDLE, and a back-to-back SW then LW from DONE issue correctly.
